// File: rtl/fifo_arb_pkg.sv
// -----------------------------------------------------------------------------
// fifo_arb_pkg
// Shared definitions for the FIFO write arbiter slice:
//   - arb_state_e   : arbiter FSM encoding (StIdle = 0, StBurst = 1)
//   - *_DEF         : default NREQ / IDXW / DATAWIDTH / BURSTLEN / BCNTW values
//   - STAT_W        : width of the optional per-requester statistics counters
// -----------------------------------------------------------------------------
package fifo_arb_pkg;

  typedef enum logic {
    StIdle  = 1'b0,
    StBurst = 1'b1
  } arb_state_e;

  localparam int unsigned NREQ_DEF      = 4;
  localparam int unsigned IDXW_DEF      = 2;
  localparam int unsigned DATAWIDTH_DEF = 8;
  localparam int unsigned BURSTLEN_DEF  = 4;
  localparam int unsigned BCNTW_DEF     = 4;

  localparam int unsigned STAT_W        = 16;

endpackage

// File: rtl/fifo_rr_pick.sv
// -----------------------------------------------------------------------------
// fifo_rr_pick
// Combinational round-robin picker: returns the first set bit of req scanning
// start, start+1, ... modulo NREQ.
// Ports:
//   req    in   NREQ   request vector
//   start  in   IDXW   index scanned first
//   found  out  1      at least one request bit is set
//   idx    out  IDXW   winning index (0 when nothing is found)
// -----------------------------------------------------------------------------
module fifo_rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDXW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] start,
  output logic            found,
  output logic [IDXW-1:0] idx
);

  logic [IDXW-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      // NREQ is a power of two, so the IDXW-bit add wraps modulo NREQ.
      cand = start + IDXW'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
// Round-robin arbiter sharing one sync FIFO write port among NREQ valid/ready
// requesters. A granted owner keeps the port for up to BURSTLEN beats, then the
// grant hands over to the next valid requester with no idle bubble.
//
// Ports:
//   clk         in   1               clock, rising edge
//   rst         in   1               asynchronous active-low reset
//   req_valid   in   NREQ            per-requester word valid
//   req_data    in   NREQ*DATAWIDTH  requester i at [i*DATAWIDTH +: DATAWIDTH]
//   req_ready   out  NREQ            per-requester accept
//   fifo_full   in   1               FIFO full flag
//   fifo_wr_en  out  1               FIFO write enable
//   fifo_din    out  DATAWIDTH       FIFO write data (0 when not writing)
//   gnt_vld     out  1               a burst owner is active
//   gnt_id      out  IDXW            current owner index
// Optional (macro ARB_STATS_EN):
//   stat_clr    in   1               synchronous clear of all counters
//   stat_cnt    out  NREQ*16         per-requester saturating accepted-word count
// -----------------------------------------------------------------------------
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NREQ      = NREQ_DEF,
  parameter int unsigned IDXW      = IDXW_DEF,
  parameter int unsigned DATAWIDTH = DATAWIDTH_DEF,
  parameter int unsigned BURSTLEN  = BURSTLEN_DEF,
  parameter int unsigned BCNTW     = BCNTW_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*DATAWIDTH-1:0] req_data,
  output logic [NREQ-1:0]           req_ready,
  input  logic                      fifo_full,
  output logic                      fifo_wr_en,
  output logic [DATAWIDTH-1:0]      fifo_din,
  output logic                      gnt_vld,
  output logic [IDXW-1:0]           gnt_id
`ifdef ARB_STATS_EN
  ,
  input  logic                      stat_clr,
  output logic [NREQ*STAT_W-1:0]    stat_cnt
`endif
);

  arb_state_e      state_q, state_d;
  logic [IDXW-1:0] owner_q, owner_d;
  logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;
  logic [BCNTW-1:0] bcnt_q, bcnt_d;

  logic [IDXW-1:0] owner_nxt;
  logic            idle_found, ho_found;
  logic [IDXW-1:0] idle_idx, ho_idx;
  logic            owner_valid, xfer, last_beat, release_burst;

  assign owner_nxt     = owner_q + 1'b1;
  assign owner_valid   = req_valid[owner_q];
  assign xfer          = (state_q == StBurst) && owner_valid && !fifo_full;
  assign last_beat     = (bcnt_q == BCNTW'(BURSTLEN - 1));
  // Owner going idle releases the grant without a transfer.
  assign release_burst = (xfer && last_beat) || !owner_valid;

  // Initial grant scans from the round-robin pointer.
  fifo_rr_pick #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_pick_idle (
    .req   (req_valid),
    .start (rr_ptr_q),
    .found (idle_found),
    .idx   (idle_idx)
  );

  // Handover scans from the slot after the current owner.
  fifo_rr_pick #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_pick_handover (
    .req   (req_valid),
    .start (owner_nxt),
    .found (ho_found),
    .idx   (ho_idx)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      bcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      bcnt_q   <= bcnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    bcnt_d   = bcnt_q;
    unique case (state_q)
      StIdle: begin
        if (idle_found) begin
          state_d = StBurst;
          owner_d = idle_idx;
          bcnt_d  = '0;
        end
      end
      StBurst: begin
        if (release_burst) begin
          rr_ptr_d = owner_nxt;
          bcnt_d   = '0;
          if (ho_found) begin
            owner_d = ho_idx;
          end else begin
            state_d = StIdle;
          end
        end else if (xfer) begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output logic.
  always_comb begin
    req_ready  = '0;
    fifo_wr_en = 1'b0;
    fifo_din   = '0;
    gnt_vld    = (state_q == StBurst);
    gnt_id     = owner_q;
    if (state_q == StBurst) begin
      req_ready[owner_q] = !fifo_full;
      fifo_wr_en         = xfer;
      if (xfer) begin
        fifo_din = req_data[owner_q*DATAWIDTH +: DATAWIDTH];
      end
    end
  end

`ifdef ARB_STATS_EN
  logic [STAT_W-1:0] cnt_q [NREQ];

  // Clear wins over a same-cycle increment; counts stick at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (stat_clr) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (xfer && (cnt_q[owner_q] != '1)) begin
      cnt_q[owner_q] <= cnt_q[owner_q] + 1'b1;
    end
  end

  always_comb begin
    stat_cnt = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      stat_cnt[i*STAT_W +: STAT_W] = cnt_q[i];
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares one sync FIFO write port among NREQ requesters.
- Each requester presents a valid/ready stream. The arbiter grants one owner at a time for a burst of up to BURSTLEN beats, muxes its data onto the FIFO write port and back-pressures on the FIFO full flag.
- Sits directly in front of the sync FIFO; the FIFO's f_full feeds this block, and this block drives the FIFO's wr_en and data_in.

Parameters:
- NREQ, 4, number of requesters (power of two, 2..8)
- IDXW, 2, log2(NREQ), requester index width
- DATAWIDTH, 8, word width; must match the FIFO
- BURSTLEN, 4, maximum beats per grant (1..16)
- BCNTW, 4, burst counter width; must satisfy 2**BCNTW >= BURSTLEN

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester word valid
- req_data  in  NREQ*DATAWIDTH  flattened data; requester i occupies bits [i*DATAWIDTH +: DATAWIDTH]
- req_ready  out  NREQ  per-requester accept
- fifo_full  in  1  FIFO full flag
- fifo_wr_en  out  1  FIFO write enable
- fifo_din  out  DATAWIDTH  FIFO write data
- gnt_vld  out  1  a burst owner is active
- gnt_id  out  IDXW  current owner index

Behaviour:
- Interface: reset rst, asynchronous, active-low; clock clk.
- Reset values: state=IDLE, owner=0, rr_ptr=0, bcnt=0, gnt_vld=0, gnt_id=0, req_ready=0, fifo_wr_en=0, fifo_din=0. A mid-operation reset aborts the burst immediately; no partial state is retained.
- States: IDLE, BURST. gnt_vld=1 exactly when state=BURST. gnt_id=owner (registered).
- Pick function: first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, … modulo NREQ.
- IDLE: if any req_valid, next state=BURST, owner=pick(rr_ptr), bcnt=0. No transfer happens in the IDLE cycle, so the first word has 1 cycle of arbitration latency.
- BURST, combinational outputs:
  - req_ready[owner] = !fifo_full; all other ready bits = 0.
  - xfer = req_valid[owner] & !fifo_full.
  - fifo_wr_en = xfer.
  - fifo_din = req_data[owner] when xfer, else 0.
- BURST release occurs when:
  - (a) xfer && bcnt==BURSTLEN-1, or
  - (b) !req_valid[owner] (owner idle; this is not a transfer cycle).
- On release: rr_ptr=owner+1 (mod NREQ). If any req_valid, stay in BURST with owner=pick(owner+1) and bcnt=0 (zero-bubble handover). Otherwise go to IDLE.
- Otherwise, if xfer, bcnt increments; if fifo_full, everything holds. There is no timeout: the grant persists while full.
- Fairness: a requester continuously valid is served within (NREQ-1)*BURSTLEN beats of other traffic.
- A sole valid requester may be re-granted back-to-back.
- Requesters must hold valid/data stable until ready; the arbiter does not check this.

Optional Feature:
- Macro ARB_STATS_EN.
- When defined:
  - Adds input stat_clr (1 bit) and output stat_cnt (NREQ*16 bits).
  - Per-requester 16-bit saturating count of accepted words (xfer with owner=i). Saturates at 16'hFFFF.
  - stat_clr zeroes all counters synchronously and takes priority over a same-cycle increment.
  - Counters reset to 0.
- When undefined: neither port exists and there is no counter logic; the arbitration behaviour is identical.

Decomposition:
- Shared package fifo_arb_pkg:
  - state encoding (IDLE=1'b0, BURST=1'b1)
  - default NREQ/IDXW/DATAWIDTH/BURSTLEN constants
  - stats counter width 16
- One combinational sub-module, fifo_rr_pick:
  - inputs: req vector, start pointer
  - outputs: found flag, winner index
  - instantiated twice: once with start=rr_ptr for IDLE, once with start=owner+1 for handover.

Test Plan:
- Single requester: reset, then req_valid=4'b0001 with data 0x10..0x15 and fifo_full=0.
  - gnt_id=0 from cycle 2.
  - Writes 0x10–0x13, one idle-free re-grant, then 0x14, 0x15.
  - fifo_wr_en high 6 of 7 cycles after grant.
- Round robin: all four requesters continuously valid, BURSTLEN=4.
  - Grant order 0,1,2,3,0.
  - Exactly 4 writes per owner.
  - Handover with no bubble: fifo_wr_en stays high across owner changes.
- Full stall: fifo_full=1 for 3 cycles mid-burst at bcnt=2.
  - req_ready and fifo_wr_en are 0 during the stall.
  - Owner and bcnt hold.
  - Burst resumes and ends after 2 more words.
- Early release: owner 2 drops valid after 1 word while requester 3 is valid.
  - Next cycle gnt_id=3, bcnt=0.
  - rr_ptr moves past 2.
- Reset mid-burst: assert rst at bcnt=2.
  - All outputs go to 0 immediately.
  - After release, arbitration restarts from requester 0.
- ARB_STATS_EN: run the round-robin case for 8 beats per requester.
  - stat_cnt reads 8 per slice.
  - Pulsing stat_clr zeroes all counters.
  - Forcing a counter to 16'hFFFF holds it at 16'hFFFF on further writes.
